// File: rtl/midi_msg_parser.sv
// midi_msg_parser
// Assembles MIDI messages from the byte stream delivered by the byte detector.
// Handles running status, real-time bytes interleaved into other messages,
// system common messages and SysEx framing. Each complete message is
// presented on a single-cycle msg_valid strobe.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active-high
//   midi_byte_in received byte, valid while byte_ready is high
//   byte_ready   level from the byte detector; a rising edge marks a new byte
//   msg_valid    one-cycle strobe, message fields below are complete
//   status       status byte of the presented message
//   data1        first data byte (0 when msg_len < 1)
//   data2        second data byte (0 when msg_len < 2)
//   msg_len      number of data bytes in the message (0..2)
//   sysex_active high between F0 and its terminator
//   err_count    saturating count of protocol errors
module midi_msg_parser #(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       midi_byte_in,
  input  logic             byte_ready,
  output logic             msg_valid,
  output logic [7:0]       status,
  output logic [6:0]       data1,
  output logic [6:0]       data2,
  output logic [1:0]       msg_len,
  output logic             sysex_active,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SYSEX} state_t;

  state_t     state;
  logic       ready_q;
  logic [7:0] cur_status;
  logic [1:0] exp_cnt;
  logic [6:0] d1_part;
  // Set for system common messages: they do not establish running status,
  // so the FSM drops back to IDLE once they are emitted.
  logic       is_common;
  // Set from a status byte until its first message is emitted; a new channel
  // status arriving while this is set means the previous message was cut short.
  logic       fresh;

  logic       accept;
  logic       partial;
  logic [ERR_W-1:0] err_inc;

  assign accept  = byte_ready & ~ready_q;
  assign partial = (state == WAIT_D2) || ((state == WAIT_D1) && fresh);
  assign err_inc = (err_count == {ERR_W{1'b1}}) ? err_count : err_count + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ready_q      <= 1'b0;
      cur_status   <= 8'h00;
      exp_cnt      <= 2'd0;
      d1_part      <= 7'h00;
      is_common    <= 1'b0;
      fresh        <= 1'b0;
      msg_valid    <= 1'b0;
      status       <= 8'h00;
      data1        <= 7'h00;
      data2        <= 7'h00;
      msg_len      <= 2'd0;
      sysex_active <= 1'b0;
      err_count    <= '0;
    end else begin
      ready_q   <= byte_ready;
      msg_valid <= 1'b0;
      if (accept) begin
        if (!midi_byte_in[7]) begin
          // Data byte
          case (state)
            IDLE: err_count <= err_inc;
            WAIT_D1: begin
              if (exp_cnt == 2'd1) begin
                msg_valid <= 1'b1;
                status    <= cur_status;
                data1     <= midi_byte_in[6:0];
                data2     <= 7'h00;
                msg_len   <= 2'd1;
                fresh     <= 1'b0;
                state     <= is_common ? IDLE : WAIT_D1;
              end else begin
                d1_part <= midi_byte_in[6:0];
                state   <= WAIT_D2;
              end
            end
            WAIT_D2: begin
              msg_valid <= 1'b1;
              status    <= cur_status;
              data1     <= d1_part;
              data2     <= midi_byte_in[6:0];
              msg_len   <= 2'd2;
              fresh     <= 1'b0;
              state     <= is_common ? IDLE : WAIT_D1;
            end
            default: ;
          endcase
        end else if (midi_byte_in >= 8'hF8) begin
          // Real-time bytes pass straight through without disturbing any
          // message in progress; the partial data1 lives in d1_part.
          msg_valid <= 1'b1;
          status    <= midi_byte_in;
          data1     <= 7'h00;
          data2     <= 7'h00;
          msg_len   <= 2'd0;
        end else begin
          // Every non-real-time status byte terminates SysEx; F0 re-arms it.
          sysex_active <= 1'b0;
          if (midi_byte_in < 8'hF0) begin
            if (partial) err_count <= err_inc;
            cur_status <= midi_byte_in;
            exp_cnt    <= (midi_byte_in[7:5] == 3'b110) ? 2'd1 : 2'd2;
            is_common  <= 1'b0;
            fresh      <= 1'b1;
            state      <= WAIT_D1;
          end else begin
            case (midi_byte_in)
              8'hF0: begin
                sysex_active <= 1'b1;
                state        <= SYSEX;
              end
              8'hF7: begin
                if (state == SYSEX) state <= IDLE;
                else err_count <= err_inc;
              end
              8'hF1, 8'hF2, 8'hF3: begin
                cur_status <= midi_byte_in;
                exp_cnt    <= (midi_byte_in == 8'hF2) ? 2'd2 : 2'd1;
                is_common  <= 1'b1;
                fresh      <= 1'b1;
                state      <= WAIT_D1;
              end
              8'hF6: begin
                msg_valid <= 1'b1;
                status    <= midi_byte_in;
                data1     <= 7'h00;
                data2     <= 7'h00;
                msg_len   <= 2'd0;
                state     <= IDLE;
              end
              default: begin
                // F4/F5 are undefined
                err_count <= err_inc;
                state     <= IDLE;
              end
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_msg_parser.sv
// Directed testbench for midi_msg_parser. Each feature has its own task that
// drives bytes and compares the captured outputs against hand-computed values.
module tb_midi_msg_parser;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] midi_byte_in;
  logic       byte_ready;
  logic       msg_valid;
  logic [7:0] status;
  logic [6:0] data1;
  logic [6:0] data2;
  logic [1:0] msg_len;
  logic       sysex_active;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  // {msg_valid, status, data1, data2, msg_len} sampled just after the accept edge
  logic [24:0] got_msg;
  logic        got_sysex;
  logic        got_after_valid;

  midi_msg_parser #(.ERR_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .midi_byte_in(midi_byte_in),
    .byte_ready(byte_ready),
    .msg_valid(msg_valid),
    .status(status),
    .data1(data1),
    .data2(data2),
    .msg_len(msg_len),
    .sysex_active(sysex_active),
    .err_count(err_count)
  );

  always #10 clk = ~clk;

  // Raises byte_ready for one cycle with the byte, captures the outputs one
  // edge later, then drops byte_ready and captures msg_valid once more.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    midi_byte_in = b;
    byte_ready   = 1'b1;
    @(posedge clk);
    #1;
    got_msg   = {msg_valid, status, data1, data2, msg_len};
    got_sysex = sysex_active;
    @(negedge clk);
    byte_ready = 1'b0;
    @(posedge clk);
    #1;
    got_after_valid = msg_valid;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    byte_ready   = 1'b0;
    midi_byte_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({msg_valid, status, data1, data2, msg_len, sysex_active, err_count} !== 34'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected 0",
               {msg_valid, status, data1, data2, msg_len, sysex_active, err_count});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (msg_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release_idle: msg_valid got %b expected 0", msg_valid);
    end
  endtask

  task automatic test_note_on();
    send_byte(8'h90);
    send_byte(8'h3C);
    checks++;
    if (got_msg[24] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL note_partial_no_emit: msg_valid got %b expected 0", got_msg[24]);
    end
    send_byte(8'h64);
    checks++;
    if (got_msg !== {1'b1, 8'h90, 7'h3C, 7'h64, 2'd2}) begin
      errors++;
      $display("[TB] FAIL note_on: got %h expected %h", got_msg, {1'b1, 8'h90, 7'h3C, 7'h64, 2'd2});
    end
    checks++;
    if (got_after_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL note_strobe_width: msg_valid got %b expected 0", got_after_valid);
    end
    send_byte(8'h3E);
    send_byte(8'h00);
    checks++;
    if (got_msg !== {1'b1, 8'h90, 7'h3E, 7'h00, 2'd2}) begin
      errors++;
      $display("[TB] FAIL running_status: got %h expected %h", got_msg, {1'b1, 8'h90, 7'h3E, 7'h00, 2'd2});
    end
  endtask

  task automatic test_program_change();
    send_byte(8'hC5);
    send_byte(8'h07);
    checks++;
    if (got_msg !== {1'b1, 8'hC5, 7'h07, 7'h00, 2'd1}) begin
      errors++;
      $display("[TB] FAIL prog_change_1: got %h expected %h", got_msg, {1'b1, 8'hC5, 7'h07, 7'h00, 2'd1});
    end
    send_byte(8'h09);
    checks++;
    if (got_msg !== {1'b1, 8'hC5, 7'h09, 7'h00, 2'd1}) begin
      errors++;
      $display("[TB] FAIL prog_change_2: got %h expected %h", got_msg, {1'b1, 8'hC5, 7'h09, 7'h00, 2'd1});
    end
  endtask

  task automatic test_realtime();
    send_byte(8'h90);
    send_byte(8'h3C);
    send_byte(8'hF8);
    checks++;
    if (got_msg !== {1'b1, 8'hF8, 7'h00, 7'h00, 2'd0}) begin
      errors++;
      $display("[TB] FAIL realtime_emit: got %h expected %h", got_msg, {1'b1, 8'hF8, 7'h00, 7'h00, 2'd0});
    end
    send_byte(8'h64);
    checks++;
    if (got_msg !== {1'b1, 8'h90, 7'h3C, 7'h64, 2'd2}) begin
      errors++;
      $display("[TB] FAIL realtime_resume: got %h expected %h", got_msg, {1'b1, 8'h90, 7'h3C, 7'h64, 2'd2});
    end
    checks++;
    if (err_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL realtime_no_err: err_count got %0d expected 0", err_count);
    end
  endtask

  task automatic test_errors();
    pulse_reset();
    send_byte(8'h45);
    checks++;
    if (got_msg[24] !== 1'b0 || err_count !== 8'd1) begin
      errors++;
      $display("[TB] FAIL stray_data: valid %b err %0d expected valid 0 err 1", got_msg[24], err_count);
    end
    send_byte(8'h90);
    send_byte(8'h3C);
    send_byte(8'hB0);
    checks++;
    if (got_msg[24] !== 1'b0 || err_count !== 8'd2) begin
      errors++;
      $display("[TB] FAIL partial_dropped: valid %b err %0d expected valid 0 err 2", got_msg[24], err_count);
    end
    send_byte(8'h07);
    send_byte(8'h7F);
    checks++;
    if (got_msg !== {1'b1, 8'hB0, 7'h07, 7'h7F, 2'd2}) begin
      errors++;
      $display("[TB] FAIL ctrl_after_drop: got %h expected %h", got_msg, {1'b1, 8'hB0, 7'h07, 7'h7F, 2'd2});
    end
  endtask

  task automatic test_sysex();
    send_byte(8'hF0);
    checks++;
    if (got_sysex !== 1'b1 || got_msg[24] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sysex_start: sysex %b valid %b expected 1 0", got_sysex, got_msg[24]);
    end
    send_byte(8'h7E);
    send_byte(8'h01);
    checks++;
    if (got_sysex !== 1'b1 || got_msg[24] !== 1'b0 || err_count !== 8'd2) begin
      errors++;
      $display("[TB] FAIL sysex_body: sysex %b valid %b err %0d expected 1 0 2", got_sysex, got_msg[24], err_count);
    end
    send_byte(8'hF7);
    checks++;
    if (got_sysex !== 1'b0 || got_msg[24] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sysex_end: sysex %b valid %b expected 0 0", got_sysex, got_msg[24]);
    end
    send_byte(8'h40);
    checks++;
    if (err_count !== 8'd3) begin
      errors++;
      $display("[TB] FAIL data_after_sysex: err_count got %0d expected 3", err_count);
    end
  endtask

  task automatic test_hold_level();
    @(negedge clk);
    midi_byte_in = 8'h40;
    byte_ready   = 1'b1;
    repeat (1000) @(posedge clk);
    @(negedge clk);
    byte_ready = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (err_count !== 8'd4) begin
      errors++;
      $display("[TB] FAIL held_level_single_accept: err_count got %0d expected 4", err_count);
    end
  endtask

  task automatic test_system_common();
    send_byte(8'hF1);
    send_byte(8'h10);
    checks++;
    if (got_msg !== {1'b1, 8'hF1, 7'h10, 7'h00, 2'd1}) begin
      errors++;
      $display("[TB] FAIL sys_common_f1: got %h expected %h", got_msg, {1'b1, 8'hF1, 7'h10, 7'h00, 2'd1});
    end
    send_byte(8'h05);
    checks++;
    if (got_msg[24] !== 1'b0 || err_count !== 8'd5) begin
      errors++;
      $display("[TB] FAIL sys_common_no_running: valid %b err %0d expected 0 5", got_msg[24], err_count);
    end
    send_byte(8'hF6);
    checks++;
    if (got_msg !== {1'b1, 8'hF6, 7'h00, 7'h00, 2'd0}) begin
      errors++;
      $display("[TB] FAIL tune_request: got %h expected %h", got_msg, {1'b1, 8'hF6, 7'h00, 7'h00, 2'd0});
    end
    send_byte(8'hF7);
    send_byte(8'hF4);
    checks++;
    if (err_count !== 8'd7) begin
      errors++;
      $display("[TB] FAIL stray_eox_undefined: err_count got %0d expected 7", err_count);
    end
  endtask

  task automatic test_reset_mid_message();
    send_byte(8'h90);
    send_byte(8'h3C);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({msg_valid, status, data1, data2, msg_len, sysex_active, err_count} !== 34'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: got %h expected 0",
               {msg_valid, status, data1, data2, msg_len, sysex_active, err_count});
    end
    rst = 1'b0;
    send_byte(8'h64);
    checks++;
    if (got_msg[24] !== 1'b0 || err_count !== 8'd1) begin
      errors++;
      $display("[TB] FAIL after_reset_data: valid %b err %0d expected 0 1", got_msg[24], err_count);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 254; i++) send_byte(8'h11);
    checks++;
    if (err_count !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL err_reach_max: err_count got %h expected ff", err_count);
    end
    send_byte(8'h11);
    send_byte(8'h22);
    checks++;
    if (err_count !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL err_saturate: err_count got %h expected ff", err_count);
    end
  endtask

  initial begin
    test_reset();
    test_note_on();
    test_program_change();
    test_realtime();
    test_errors();
    test_sysex();
    test_hold_level();
    test_system_common();
    test_reset_mid_message();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/midi_msg_parser.md
Name: midi_msg_parser

Overview:
Downstream consumer of the MIDI byte detector. Takes each received byte and assembles complete MIDI messages: status plus 0–2 data bytes. Handles running status, interleaved real-time bytes and SysEx. Presents one message per single-cycle strobe to the note/control logic downstream.

Parameters:
ERR_W, 8, width of saturating protocol-error counter

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  asynchronous reset, active-high
midi_byte_in  input  8  byte from byte detector; valid while byte_ready high
byte_ready  input  1  level from byte detector; a new byte is signalled by its 0->1 transition
msg_valid  output  1  one-cycle strobe: status/data1/data2/msg_len hold a complete message
status  output  8  status byte of the message
data1  output  7  first data byte (0 if msg_len<1)
data2  output  7  second data byte (0 if msg_len<2)
msg_len  output  2  number of data bytes (0..2)
sysex_active  output  1  high between F0 and its terminator
err_count  output  ERR_W  saturating count of protocol errors

Behaviour:
- Reset (async, rst=1): msg_valid=0, status=0, data1=0, data2=0, msg_len=0, sysex_active=0, err_count=0. Internal state: FSM=IDLE, running status cleared, byte_ready history register=0. A message in progress is discarded; nothing is emitted after reset releases until new bytes arrive.
- Byte accept: a registered copy of byte_ready is kept. The accept cycle is any cycle where byte_ready=1 and the registered copy=0. midi_byte_in is sampled in that cycle only. A level held high yields exactly one accept.
- Latency: msg_valid is asserted on the clock edge following the accept cycle of the completing byte, for exactly one cycle. status/data1/data2/msg_len update on the same edge and hold until the next msg_valid.
- Expected data count per status:
  - 8x, 9x, Ax, Bx, Ex -> 2
  - Cx, Dx -> 1
  - F1, F3 -> 1
  - F2 -> 2
  - F6 -> 0
- FSM states: IDLE (no running status), WAIT_D1, WAIT_D2, SYSEX.
- Channel status (80–EF): clears sysex_active, stores running status, goes to WAIT_D1. If a partial message was pending, err_count increments and the partial is dropped.
- Data byte (bit7=0):
  - In WAIT_D1: latch data1. If expected=1, emit and return to WAIT_D1 with running status retained; otherwise go to WAIT_D2.
  - In WAIT_D2: latch data2, emit, return to WAIT_D1 (running status retained).
  - In IDLE: byte dropped, err_count increments.
  - In SYSEX: byte ignored silently.
- System common (F1, F2, F3, F6): clear running status. F6 emits immediately with msg_len=0 and goes to IDLE. Others go to WAIT_D1 using their own expected count; after emitting, go to IDLE, not WAIT_D1.
- F0: clears running status, sets sysex_active=1, enters SYSEX. No message is emitted.
- F7:
  - In SYSEX: clears sysex_active, goes to IDLE, no emit.
  - Elsewhere: err_count increments; state is unchanged.
- Any other non-real-time status byte ends SysEx (sysex_active=0) without an error and is then processed normally.
- F4, F5: undefined. err_count increments, running status cleared, go to IDLE.
- Real-time (F8–FF):
  - Emitted immediately with msg_len=0.
  - FSM state, running status, partial data1 and sysex_active are left untouched, so the interrupted message continues afterwards.
  - The output registers for data1/data2 reflect the real-time message (both 0). The partial data1 is kept in a separate internal register.
- err_count saturates at 2^ERR_W−1; it never wraps.
- Only one byte can be accepted per cycle, so simultaneous events cannot occur. An error increment and a new status byte in the same accept are both applied.

Test Plan:
- Bytes 90,3C,64 -> one msg_valid: status=90, data1=3C, data2=64, msg_len=2, exactly one cycle after the third accept. Then 3E,00 -> second msg with status=90, data1=3E, data2=00 (running status).
- Bytes C5,07,09 -> two messages: (C5,07,len1) then (C5,09,len1).
- Bytes 90,3C,F8,64:
  - F8 emits status=F8, len0, immediately.
  - Then (90,3C,64,len2); no errors.
- Bytes 45 after reset -> no msg_valid, err_count=1. Then 90,3C,B0 -> err_count=2, no emit for the 90 message. Then 07,7F -> (B0,07,7F).
- Bytes F0,7E,01,F7 -> sysex_active rises at the F0 accept+1 and falls after F7, no msg_valid. Then 40 -> err_count+1 (running status cleared). Also hold byte_ready high 1000 cycles -> single accept only.
- Assert rst for 1 ns mid-message (after 90,3C) -> all outputs 0 immediately. Then 64 -> no emit, err_count=1. Then 256 stray data bytes with ERR_W=8 -> err_count=FF and stays FF.
